// File: rtl/sw_array_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sw_array_ctrl_pkg
// Shared constants and types for the Smith-Waterman array sequencer.
//   SW_CALC_BIT / SW_PE_NUM / SW_LEN_BIT : default widths and chain length
//   TOK_IDLE / TOK_LOADQ / TOK_VALID     : token encodings on the 3-bit links
//   sw_state_t                           : sequencer states
//   valid_tok()                          : builds a {valid, base} token
// ---------------------------------------------------------------------------
package sw_array_ctrl_pkg;

   localparam int SW_CALC_BIT = 12;
   localparam int SW_PE_NUM   = 64;
   localparam int SW_LEN_BIT  = 16;

   // Token on the query / target links: bit TOK_VALID marks a base,
   // TOK_LOADQ (no valid bit, lsb set) tells each PE to latch its query.
   localparam logic [2:0] TOK_IDLE  = 3'b000;
   localparam logic [2:0] TOK_LOADQ = 3'b001;
   localparam int         TOK_VALID = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADQ  = 3'd1,
      ST_COMMIT = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } sw_state_t;

   function automatic logic [2:0] valid_tok(input logic [1:0] base);
      logic [2:0] tok;
      tok            = TOK_IDLE;
      tok[TOK_VALID] = 1'b1;
      tok[1:0]       = base;
      return tok;
   endfunction

endpackage

// File: rtl/sw_score_cfg.sv
// ---------------------------------------------------------------------------
// sw_score_cfg
// Scoring configuration registers plus the affine pre-sums broadcast to
// every PE. Everything is captured on load and held until the next load.
//   clk, rst                              : clock, async active-high reset
//   load                                  : capture strobe (accepted start)
//   match_i, mismatch_i, alpha_i, beta_i  : signed scores from the host
//   match_o, mismatch_o, alpha_o, beta_o  : latched scores
//   a2_o, ab_o, ma_a_o, mis_a_o           : alpha+alpha, alpha+beta,
//                                           match+alpha, mismatch+alpha
// ---------------------------------------------------------------------------
module sw_score_cfg
   import sw_array_ctrl_pkg::*;
#(
   parameter int CALC_BIT = SW_CALC_BIT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic signed [CALC_BIT-1:0] match_i,
   input  logic signed [CALC_BIT-1:0] mismatch_i,
   input  logic signed [CALC_BIT-1:0] alpha_i,
   input  logic signed [CALC_BIT-1:0] beta_i,
   output logic signed [CALC_BIT-1:0] match_o,
   output logic signed [CALC_BIT-1:0] mismatch_o,
   output logic signed [CALC_BIT-1:0] alpha_o,
   output logic signed [CALC_BIT-1:0] beta_o,
   output logic signed [CALC_BIT-1:0] a2_o,
   output logic signed [CALC_BIT-1:0] ab_o,
   output logic signed [CALC_BIT-1:0] ma_a_o,
   output logic signed [CALC_BIT-1:0] mis_a_o
);

   // Pre-sums are computed from the inputs, not the latched copies, so they
   // become valid in the same cycle as the configuration itself. Sums wrap
   // at CALC_BIT; the host keeps them in range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_o    <= '0;
         mismatch_o <= '0;
         alpha_o    <= '0;
         beta_o     <= '0;
         a2_o       <= '0;
         ab_o       <= '0;
         ma_a_o     <= '0;
         mis_a_o    <= '0;
      end else if (load) begin
         match_o    <= match_i;
         mismatch_o <= mismatch_i;
         alpha_o    <= alpha_i;
         beta_o     <= beta_i;
         a2_o       <= alpha_i + alpha_i;
         ab_o       <= alpha_i + beta_i;
         ma_a_o     <= match_i + alpha_i;
         mis_a_o    <= mismatch_i + alpha_i;
      end
   end

endmodule

// File: rtl/sw_array_ctrl.sv
// ---------------------------------------------------------------------------
// sw_array_ctrl
// Sequencer for the linear systolic Smith-Waterman PE chain. Latches the
// scoring configuration, shifts the query into the chain, commits it with a
// load token, streams target bases into PE[0], drains the pipeline and
// captures the final max score from the chain tail.
//   clk, rst                     : clock, async active-high reset
//   start, q_len, *_i scores     : job start pulse and its parameters
//   q_valid/q_data/q_ready       : query base stream
//   t_valid/t_data/t_last/t_ready: target base stream
//   match_o..mis_a_o             : configuration and pre-sums to the PEs
//   q_shift_o, q_o               : query shift-chain enable and token
//   t_o                          : token into PE[0]
//   max_tail_i                   : max output of the last PE
//   busy, done, score            : job status and result
//   state_dbg                    : current sequencer state
//
// Handshake: a base is transferred in a cycle where valid and ready are both
// high. ready is a registered function of state only and never depends on
// valid; valid may rise or fall freely and is ignored while ready is low.
// ---------------------------------------------------------------------------
module sw_array_ctrl
   import sw_array_ctrl_pkg::*;
#(
   parameter int PE_NUM   = SW_PE_NUM,
   parameter int CALC_BIT = SW_CALC_BIT,
   parameter int LEN_BIT  = SW_LEN_BIT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [$clog2(PE_NUM+1)-1:0] q_len,
   input  logic signed [CALC_BIT-1:0]  match_i,
   input  logic signed [CALC_BIT-1:0]  mismatch_i,
   input  logic signed [CALC_BIT-1:0]  alpha_i,
   input  logic signed [CALC_BIT-1:0]  beta_i,
   input  logic                        q_valid,
   input  logic [1:0]                  q_data,
   output logic                        q_ready,
   input  logic                        t_valid,
   input  logic [1:0]                  t_data,
   input  logic                        t_last,
   output logic                        t_ready,
   output logic signed [CALC_BIT-1:0]  match_o,
   output logic signed [CALC_BIT-1:0]  mismatch_o,
   output logic signed [CALC_BIT-1:0]  alpha_o,
   output logic signed [CALC_BIT-1:0]  beta_o,
   output logic signed [CALC_BIT-1:0]  a2_o,
   output logic signed [CALC_BIT-1:0]  ab_o,
   output logic signed [CALC_BIT-1:0]  ma_a_o,
   output logic signed [CALC_BIT-1:0]  mis_a_o,
   output logic                        q_shift_o,
   output logic [2:0]                  q_o,
   output logic [2:0]                  t_o,
   input  logic signed [CALC_BIT-1:0]  max_tail_i,
   output logic                        busy,
   output logic                        done,
   output logic signed [CALC_BIT-1:0]  score,
   output sw_state_t                   state_dbg
);

   localparam int QW        = $clog2(PE_NUM+1);
   // Two register stages per PE plus the v/max output pair.
   localparam int DRAIN_LEN = 2*PE_NUM + 2;
   localparam int DW        = $clog2(DRAIN_LEN);

   localparam logic [QW-1:0]      Q_MAX  = QW'(PE_NUM);
   localparam logic [QW-1:0]      Q_LAST = QW'(PE_NUM-1);
   localparam logic [DW-1:0]      D_LAST = DW'(DRAIN_LEN-1);
   localparam logic [LEN_BIT-1:0] T_MAX  = '1;

   sw_state_t          state_q;
   logic [QW-1:0]      qlen_q;
   logic [QW-1:0]      shift_cnt;
   logic               pad_q;
   logic               commit_q;
   logic [DW-1:0]      drain_cnt;
   logic [LEN_BIT-1:0] t_cnt;

   logic          q_fire;
   logic          t_fire;
   logic          cfg_load;
   logic [QW-1:0] qlen_eff;

   assign q_fire   = q_ready & q_valid;
   assign t_fire   = t_ready & t_valid;
   assign cfg_load = start & (state_q == ST_IDLE);
   assign qlen_eff = (q_len > Q_MAX) ? Q_MAX : q_len;

   // Link outputs are gated by registered flags, so they fall to idle the
   // moment reset clears those flags, whatever the stream inputs are doing.
   assign q_shift_o = q_fire | pad_q;
   assign q_o       = q_fire ? valid_tok(q_data) : TOK_IDLE;
   assign t_o       = commit_q ? TOK_LOADQ :
                      (t_fire ? valid_tok(t_data) : TOK_IDLE);
   assign state_dbg = state_q;

   sw_score_cfg #(.CALC_BIT(CALC_BIT)) u_cfg (
      .clk        (clk),
      .rst        (rst),
      .load       (cfg_load),
      .match_i    (match_i),
      .mismatch_i (mismatch_i),
      .alpha_i    (alpha_i),
      .beta_i     (beta_i),
      .match_o    (match_o),
      .mismatch_o (mismatch_o),
      .alpha_o    (alpha_o),
      .beta_o     (beta_o),
      .a2_o       (a2_o),
      .ab_o       (ab_o),
      .ma_a_o     (ma_a_o),
      .mis_a_o    (mis_a_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         qlen_q    <= '0;
         shift_cnt <= '0;
         pad_q     <= 1'b0;
         commit_q  <= 1'b0;
         drain_cnt <= '0;
         t_cnt     <= '0;
         q_ready   <= 1'b0;
         t_ready   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         score     <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  qlen_q    <= qlen_eff;
                  shift_cnt <= '0;
                  t_cnt     <= '0;
                  if (qlen_eff == '0) begin
                     score   <= '0;
                     done    <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     q_ready <= 1'b1;
                     state_q <= ST_LOADQ;
                  end
               end
            end
            // PE_NUM shifts in total: q_len handshaked bases first, then
            // free-running padding so the first base lands in PE[0].
            ST_LOADQ: begin
               if (q_fire | pad_q) begin
                  shift_cnt <= shift_cnt + QW'(1);
                  if (shift_cnt == Q_LAST) begin
                     q_ready  <= 1'b0;
                     pad_q    <= 1'b0;
                     commit_q <= 1'b1;
                     state_q  <= ST_COMMIT;
                  end else if (shift_cnt + QW'(1) >= qlen_q) begin
                     q_ready <= 1'b0;
                     pad_q   <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               commit_q <= 1'b0;
               t_ready  <= 1'b1;
               state_q  <= ST_RUN;
            end
            ST_RUN: begin
               if (t_fire) begin
                  if (t_cnt != T_MAX) t_cnt <= t_cnt + LEN_BIT'(1);
                  if (t_last) begin
                     t_ready   <= 1'b0;
                     drain_cnt <= '0;
                     state_q   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == D_LAST) begin
                  score   <= (t_cnt == '0) ? '0 : max_tail_i;
                  done    <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sw_array_ctrl
// Directed bench for sw_array_ctrl with an 8-PE chain. Each scenario task
// drives its stimulus and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sw_array_ctrl;
   import sw_array_ctrl_pkg::*;

   logic              clk;
   logic              rst;
   logic              start;
   logic [3:0]        q_len;
   logic signed [11:0] match_i, mismatch_i, alpha_i, beta_i;
   logic              q_valid;
   logic [1:0]        q_data;
   logic              q_ready;
   logic              t_valid;
   logic [1:0]        t_data;
   logic              t_last;
   logic              t_ready;
   logic signed [11:0] match_o, mismatch_o, alpha_o, beta_o;
   logic signed [11:0] a2_o, ab_o, ma_a_o, mis_a_o;
   logic              q_shift_o;
   logic [2:0]        q_o;
   logic [2:0]        t_o;
   logic signed [11:0] max_tail_i;
   logic              busy;
   logic              done;
   logic signed [11:0] score;
   sw_state_t         state_dbg;

   int checks = 0;
   int fails  = 0;
   int done_seen = 0;
   logic [2:0] q_obs[$];
   logic [2:0] t_obs[$];
   logic [2:0] exp_q[$];

   sw_array_ctrl #(.PE_NUM(8), .CALC_BIT(12), .LEN_BIT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .q_len(q_len),
      .match_i(match_i), .mismatch_i(mismatch_i), .alpha_i(alpha_i), .beta_i(beta_i),
      .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
      .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ready(t_ready),
      .match_o(match_o), .mismatch_o(mismatch_o), .alpha_o(alpha_o), .beta_o(beta_o),
      .a2_o(a2_o), .ab_o(ab_o), .ma_a_o(ma_a_o), .mis_a_o(mis_a_o),
      .q_shift_o(q_shift_o), .q_o(q_o), .t_o(t_o), .max_tail_i(max_tail_i),
      .busy(busy), .done(done), .score(score), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- link monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (q_shift_o) q_obs.push_back(q_o);
         if (t_o != 3'b000) t_obs.push_back(t_o);
         if (done) done_seen++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_start(input logic [3:0] len, input logic signed [11:0] m,
                             input logic signed [11:0] mm, input logic signed [11:0] a,
                             input logic signed [11:0] b);
      start = 1'b1; q_len = len;
      match_i = m; mismatch_i = mm; alpha_i = a; beta_i = b;
      cyc();
      start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b1; q_valid = 1'b1; t_valid = 1'b1;
      q_data = 2'd3; t_data = 2'd3; q_len = 4'd3; match_i = 12'sd7; alpha_i = 12'sd7;
      repeat (2) cyc();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (score !== 12'sd0) begin fails++; $display("FAIL reset_score got %0d want 0", score); end
      checks++; if (q_ready !== 1'b0) begin fails++; $display("FAIL reset_q_ready got %b want 0", q_ready); end
      checks++; if (t_ready !== 1'b0) begin fails++; $display("FAIL reset_t_ready got %b want 0", t_ready); end
      checks++; if (q_shift_o !== 1'b0) begin fails++; $display("FAIL reset_q_shift got %b want 0", q_shift_o); end
      checks++; if (q_o !== 3'b000) begin fails++; $display("FAIL reset_q_o got %b want 000", q_o); end
      checks++; if (t_o !== 3'b000) begin fails++; $display("FAIL reset_t_o got %b want 000", t_o); end
      checks++; if (match_o !== 12'sd0) begin fails++; $display("FAIL reset_match got %0d want 0", match_o); end
      checks++; if (a2_o !== 12'sd0) begin fails++; $display("FAIL reset_a2 got %0d want 0", a2_o); end
      checks++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL reset_state got %0d want 0", state_dbg); end
      @(posedge clk); #1;
      start = 1'b0; q_valid = 1'b0; t_valid = 1'b0; rst = 1'b0;
      cyc();
   endtask

   task automatic test_config();
      q_obs.delete(); t_obs.delete(); done_seen = 0;
      send_start(4'd3, 12'sd2, -12'sd1, -12'sd3, -12'sd1);
      @(negedge clk);
      checks++; if (match_o !== 12'sd2) begin fails++; $display("FAIL cfg_match got %0d want 2", match_o); end
      checks++; if (mismatch_o !== -12'sd1) begin fails++; $display("FAIL cfg_mismatch got %0d want -1", mismatch_o); end
      checks++; if (alpha_o !== -12'sd3) begin fails++; $display("FAIL cfg_alpha got %0d want -3", alpha_o); end
      checks++; if (beta_o !== -12'sd1) begin fails++; $display("FAIL cfg_beta got %0d want -1", beta_o); end
      checks++; if (a2_o !== -12'sd6) begin fails++; $display("FAIL cfg_a2 got %0d want -6", a2_o); end
      checks++; if (ab_o !== -12'sd4) begin fails++; $display("FAIL cfg_ab got %0d want -4", ab_o); end
      checks++; if (ma_a_o !== -12'sd1) begin fails++; $display("FAIL cfg_ma_a got %0d want -1", ma_a_o); end
      checks++; if (mis_a_o !== -12'sd4) begin fails++; $display("FAIL cfg_mis_a got %0d want -4", mis_a_o); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL cfg_busy got %b want 1", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_query_load();
      int commit_c;
      commit_c = 0;
      for (int c = 1; c <= 30; c++) begin
         q_valid = (c != 2);
         q_data  = (c == 1) ? 2'd0 : (c == 3) ? 2'd1 : (c == 4) ? 2'd2 : 2'd3;
         @(negedge clk);
         if (c == 2) begin
            checks++; if (q_ready !== 1'b1) begin fails++; $display("FAIL q_ready_gap got %b want 1", q_ready); end
         end
         if (c == 5) begin
            checks++; if (q_ready !== 1'b0) begin fails++; $display("FAIL q_ready_pad got %b want 0", q_ready); end
            checks++; if (q_shift_o !== 1'b1) begin fails++; $display("FAIL q_shift_pad got %b want 1", q_shift_o); end
         end
         if (t_o == 3'b001) begin
            commit_c = c;
            break;
         end
         @(posedge clk); #1;
      end
      q_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (commit_c != 10) begin fails++; $display("FAIL commit_cycle got %0d want 10", commit_c); end
      exp_q = '{3'b100, 3'b101, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      checks++;
      if (q_obs.size() != 8) begin
         fails++; $display("FAIL q_shift_count got %0d want 8", q_obs.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (q_obs[i] !== exp_q[i]) begin fails++; $display("FAIL q_shift_%0d got %b want %b", i, q_obs[i], exp_q[i]); end
         end
      end
      checks++; if (t_obs.size() != 1) begin fails++; $display("FAIL commit_tokens got %0d want 1", t_obs.size()); end
   endtask

   task automatic test_target_stream();
      for (int r = 1; r <= 7; r++) begin
         t_valid = (r % 2 == 1);
         t_data  = 2'(3 - (r - 1) / 2);
         t_last  = (r == 7);
         start   = (r == 2);
         if (r == 2) begin q_len = 4'd1; match_i = 12'sd9; alpha_i = 12'sd9; end
         max_tail_i = 12'sd50;
         @(negedge clk);
         if (r == 1) begin
            checks++; if (t_ready !== 1'b1) begin fails++; $display("FAIL t_ready_run got %b want 1", t_ready); end
         end
         if (r == 2) begin
            checks++; if (t_o !== 3'b000) begin fails++; $display("FAIL t_bubble got %b want 000", t_o); end
         end
         @(posedge clk); #1;
      end
      t_valid = 1'b0; t_last = 1'b0; start = 1'b0;
   endtask

   task automatic test_drain_score();
      int early;
      early = 0;
      for (int d = 1; d <= 18; d++) begin
         max_tail_i = 12'(100 + d);
         @(negedge clk);
         if (d == 1) begin
            checks++; if (t_ready !== 1'b0) begin fails++; $display("FAIL t_ready_drain got %b want 0", t_ready); end
         end
         if (done) early++;
         @(posedge clk); #1;
      end
      max_tail_i = 12'sd0;
      @(negedge clk);
      checks++; if (early != 0) begin fails++; $display("FAIL early_done got %0d want 0", early); end
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL done_pulse got %b want 1", done); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_done got %b want 1", busy); end
      checks++; if (score !== 12'sd118) begin fails++; $display("FAIL score got %0d want 118", score); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL done_after got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after got %b want 0", busy); end
      checks++; if (score !== 12'sd118) begin fails++; $display("FAIL score_held got %0d want 118", score); end
      checks++; if (done_seen != 1) begin fails++; $display("FAIL done_count got %0d want 1", done_seen); end
      exp_q = '{3'b001, 3'b111, 3'b110, 3'b101, 3'b100};
      checks++;
      if (t_obs.size() != 5) begin
         fails++; $display("FAIL t_token_count got %0d want 5", t_obs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (t_obs[i] !== exp_q[i]) begin fails++; $display("FAIL t_token_%0d got %b want %b", i, t_obs[i], exp_q[i]); end
         end
      end
      checks++; if (match_o !== 12'sd2) begin fails++; $display("FAIL cfg_held_match got %0d want 2", match_o); end
      checks++; if (a2_o !== -12'sd6) begin fails++; $display("FAIL cfg_held_a2 got %0d want -6", a2_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_qlen_zero();
      q_obs.delete(); t_obs.delete(); done_seen = 0;
      send_start(4'd0, 12'sd1, 12'sd1, 12'sd1, 12'sd1);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL q0_done got %b want 1", done); end
      checks++; if (score !== 12'sd0) begin fails++; $display("FAIL q0_score got %0d want 0", score); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL q0_done_end got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL q0_busy got %b want 0", busy); end
      checks++; if (q_obs.size() != 0) begin fails++; $display("FAIL q0_shifts got %0d want 0", q_obs.size()); end
      checks++; if (t_obs.size() != 0) begin fails++; $display("FAIL q0_tokens got %0d want 0", t_obs.size()); end
      checks++; if (done_seen != 1) begin fails++; $display("FAIL q0_done_count got %0d want 1", done_seen); end
      checks++; if (a2_o !== 12'sd2) begin fails++; $display("FAIL q0_a2 got %0d want 2", a2_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int commit_c;
      commit_c = 0;
      q_obs.delete(); t_obs.delete(); done_seen = 0;
      send_start(4'd2, 12'sd3, -12'sd2, -12'sd4, -12'sd2);
      q_valid = 1'b1; q_data = 2'd1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (t_o == 3'b001) begin commit_c = c; break; end
         @(posedge clk); #1;
      end
      q_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (commit_c != 9) begin fails++; $display("FAIL rr_commit_cycle got %0d want 9", commit_c); end
      t_valid = 1'b1; t_data = 2'd2; t_last = 1'b0;
      cyc();
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_busy got %b want 0", busy); end
      checks++; if (t_ready !== 1'b0) begin fails++; $display("FAIL rr_t_ready got %b want 0", t_ready); end
      checks++; if (t_o !== 3'b000) begin fails++; $display("FAIL rr_t_o got %b want 000", t_o); end
      checks++; if (match_o !== 12'sd0) begin fails++; $display("FAIL rr_match got %0d want 0", match_o); end
      checks++; if (mis_a_o !== 12'sd0) begin fails++; $display("FAIL rr_mis_a got %0d want 0", mis_a_o); end
      checks++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL rr_state got %0d want 0", state_dbg); end
      t_valid = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      checks++; if (done_seen != 0) begin fails++; $display("FAIL rr_done_count got %0d want 0", done_seen); end
   endtask

   task automatic test_restart_ignore();
      int commit_c;
      int early;
      commit_c = 0; early = 0;
      q_obs.delete(); t_obs.delete(); done_seen = 0;
      send_start(4'd15, 12'sd4, -12'sd3, -12'sd5, -12'sd2);
      for (int c = 1; c <= 20; c++) begin
         q_valid = 1'b1;
         q_data  = 2'(c % 4);
         start   = (c == 3);
         if (c == 3) begin match_i = 12'sd0; alpha_i = 12'sd0; mismatch_i = 12'sd0; end
         @(negedge clk);
         if (t_o == 3'b001) begin commit_c = c; break; end
         @(posedge clk); #1;
      end
      q_valid = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      t_valid = 1'b1; t_data = 2'd2; t_last = 1'b1; start = 1'b1;
      cyc();
      t_valid = 1'b0; t_last = 1'b0; start = 1'b0;
      for (int d = 1; d <= 18; d++) begin
         max_tail_i = (d == 18) ? -12'sd5 : 12'sd77;
         start = (d == 5);
         @(negedge clk);
         if (done) early++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      @(negedge clk);
      checks++; if (early != 0) begin fails++; $display("FAIL ri_early_done got %0d want 0", early); end
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL ri_done got %b want 1", done); end
      checks++; if (score !== -12'sd5) begin fails++; $display("FAIL ri_score got %0d want -5", score); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ri_busy got %b want 0", busy); end
      checks++; if (commit_c != 9) begin fails++; $display("FAIL ri_commit_cycle got %0d want 9", commit_c); end
      exp_q = '{3'b101, 3'b110, 3'b111, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100};
      checks++;
      if (q_obs.size() != 8) begin
         fails++; $display("FAIL ri_shift_count got %0d want 8", q_obs.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (q_obs[i] !== exp_q[i]) begin fails++; $display("FAIL ri_shift_%0d got %b want %b", i, q_obs[i], exp_q[i]); end
         end
      end
      exp_q = '{3'b001, 3'b110};
      checks++;
      if (t_obs.size() != 2) begin
         fails++; $display("FAIL ri_token_count got %0d want 2", t_obs.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++; if (t_obs[i] !== exp_q[i]) begin fails++; $display("FAIL ri_token_%0d got %b want %b", i, t_obs[i], exp_q[i]); end
         end
      end
      checks++; if (done_seen != 1) begin fails++; $display("FAIL ri_done_count got %0d want 1", done_seen); end
      checks++; if (match_o !== 12'sd4) begin fails++; $display("FAIL ri_match got %0d want 4", match_o); end
      checks++; if (a2_o !== -12'sd10) begin fails++; $display("FAIL ri_a2 got %0d want -10", a2_o); end
      checks++; if (ab_o !== -12'sd7) begin fails++; $display("FAIL ri_ab got %0d want -7", ab_o); end
      checks++; if (mis_a_o !== -12'sd8) begin fails++; $display("FAIL ri_mis_a got %0d want -8", mis_a_o); end
      @(posedge clk); #1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; start = 1'b0; q_len = '0;
      match_i = '0; mismatch_i = '0; alpha_i = '0; beta_i = '0;
      q_valid = 1'b0; q_data = '0; t_valid = 1'b0; t_data = '0; t_last = 1'b0;
      max_tail_i = '0;
      test_reset();
      test_config();
      test_query_load();
      test_target_stream();
      test_drain_score();
      test_qlen_zero();
      test_reset_mid_run();
      test_restart_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
